// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, flag struct and flag width shared by the flag ALU datapath.
package alu_pkg;
   localparam int FLAG_W = 4;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;
   typedef struct packed {
      logic c;
      logic v;
      logic n;
      logic z;
   } alu_flags_t;
endpackage

// File: rtl/csa_addsub.sv
// csa_addsub: combinational carry-select adder/subtractor built from CSA_BLK-wide ripple blocks.
module csa_addsub #(
   parameter int WIDTH   = 16,
   parameter int CSA_BLK = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NB = WIDTH / CSA_BLK;
   localparam logic [CSA_BLK:0] ONE = 1;
   logic [WIDTH-1:0] bx;
   logic [NB:0] c;
   assign bx = sub ? ~b : b;
   assign c[0] = sub;
   // each block precomputes both carry-in cases; the incoming carry only selects
   for (genvar i = 0; i < NB; i++) begin : g_blk
      logic [CSA_BLK:0] r0, r1;
      assign r0 = {1'b0, a[i*CSA_BLK +: CSA_BLK]} + {1'b0, bx[i*CSA_BLK +: CSA_BLK]};
      assign r1 = {1'b0, a[i*CSA_BLK +: CSA_BLK]} + {1'b0, bx[i*CSA_BLK +: CSA_BLK]} + ONE;
      assign sum[i*CSA_BLK +: CSA_BLK] = c[i] ? r1[CSA_BLK-1:0] : r0[CSA_BLK-1:0];
      assign c[i+1] = c[i] ? r1[CSA_BLK] : r0[CSA_BLK];
   end
   assign cout = c[NB];
   assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/pipelined_flag_alu.sv
// pipelined_flag_alu: two-stage valid/ready ALU with C/V/N/Z flags and sticky overflow.
// Define ALU_SATURATE_EN to clamp overflowing ADD/SUB results to the signed extreme.
module pipelined_flag_alu
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int CSA_BLK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [2:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic [FLAG_W-1:0] out_flags,
   output logic              ovf_sticky,
   input  logic              ovf_clr
);
   localparam int SW = $clog2(WIDTH);
   logic             s1_valid, s1_en, s2_en;
   logic [WIDTH-1:0] s1_a, s1_b;
   alu_op_e          s1_op;
   logic [WIDTH-1:0] sum, arith, shl_r, shr_r, res;
   logic             cout, ovf, shl_c, shr_c;
   logic [SW-1:0]    sh;
   alu_flags_t       flags, flags_q;
   assign s2_en = !out_valid || out_ready;
   assign s1_en = !s1_valid || s2_en;
   assign in_ready = s1_en;
   assign sh = s1_b[SW-1:0];
   // the extra bit catches the last bit shifted out, which is zero for a zero shift
   assign {shl_c, shl_r} = {1'b0, s1_a} << sh;
   assign {shr_r, shr_c} = {s1_a, 1'b0} >> sh;
   csa_addsub #(.WIDTH(WIDTH), .CSA_BLK(CSA_BLK)) u_addsub (
      .a(s1_a), .b(s1_b), .sub(s1_op == OP_SUB), .sum(sum), .cout(cout), .ovf(ovf)
   );
`ifdef ALU_SATURATE_EN
   assign arith = ovf ? {s1_a[WIDTH-1], {(WIDTH-1){~s1_a[WIDTH-1]}}} : sum;
`else
   assign arith = sum;
`endif
   always_comb begin
      res = arith;
      flags = '0;
      case (s1_op)
         OP_ADD, OP_SUB: begin
            flags.c = cout;
            flags.v = ovf;
            flags.n = arith[WIDTH-1];
         end
         OP_AND: res = s1_a & s1_b;
         OP_OR:  res = s1_a | s1_b;
         OP_XOR: res = s1_a ^ s1_b;
         OP_NOT: res = ~s1_a;
         OP_SHL: begin
            res = shl_r;
            flags.c = shl_c;
            flags.n = shl_r[WIDTH-1];
         end
         OP_SHR: begin
            res = shr_r;
            flags.c = shr_c;
            flags.n = shr_r[WIDTH-1];
         end
      endcase
      flags.z = res == '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_op      <= OP_ADD;
         out_valid  <= 1'b0;
         out_result <= '0;
         flags_q    <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_a  <= in_a;
               s1_b  <= in_b;
               s1_op <= alu_op_e'(in_op);
            end
         end
         if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_result <= res;
               flags_q    <= flags;
            end
         end
         ovf_sticky <= (out_valid && out_ready && flags_q.v) || (ovf_sticky && !ovf_clr);
      end
   end
   assign out_flags = flags_q;
endmodule

// File: tb/tb_pipelined_flag_alu.sv
// tb_pipelined_flag_alu: directed and random scoreboard bench for pipelined_flag_alu at WIDTH=16.
module tb_pipelined_flag_alu;
   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, NOT_ = 3'd5, SHL = 3'd6, SHR = 3'd7;
   typedef struct {
      logic [15:0] r;
      logic [3:0]  f;
   } exp_t;
   logic        clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready, ovf_sticky, ovf_clr;
   logic [15:0] in_a, in_b, out_result;
   logic [2:0]  in_op;
   logic [3:0]  out_flags;
   exp_t        q[$];
   int          tests = 0, fails = 0, npush = 0, npop = 0;
   pipelined_flag_alu #(.WIDTH(16), .CSA_BLK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
      .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );
   always #5 clk = ~clk;
   function automatic exp_t model(input logic [15:0] a, b, input logic [2:0] op);
      exp_t e;
      logic [16:0] t;
      logic c, v, n;
      int s;
      s = int'(b[3:0]);
      c = 0; v = 0; n = 0;
      e.r = 0;
      case (op)
         ADD: begin
            t = {1'b0, a} + {1'b0, b};
            e.r = t[15:0]; c = t[16];
            v = (a[15] == b[15]) && (e.r[15] != a[15]);
         end
         SUB: begin
            t = {1'b0, a} + {1'b0, ~b} + 17'd1;
            e.r = t[15:0]; c = t[16];
            v = (a[15] != b[15]) && (e.r[15] != a[15]);
         end
         AND_: e.r = a & b;
         OR_:  e.r = a | b;
         XOR_: e.r = a ^ b;
         NOT_: e.r = ~a;
         SHL: begin
            e.r = a << s;
            c = (s == 0) ? 1'b0 : a[16-s];
         end
         default: begin
            e.r = a >> s;
            c = (s == 0) ? 1'b0 : a[s-1];
         end
      endcase
`ifdef ALU_SATURATE_EN
      if (v) e.r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      if (op == ADD || op == SUB || op == SHL || op == SHR) n = e.r[15];
      e.f = {c, v, n, e.r == 16'h0};
      return e;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid && out_ready) begin
         chk("sb_nonempty", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            npop++;
            chk("result", out_result, e.r);
            chk("flags", out_flags, e.f);
         end
      end
      if (rst_n === 1'b1 && in_valid && in_ready) begin
         q.push_back(model(in_a, in_b, in_op));
         npush++;
      end
   end
   task automatic send(input logic [15:0] a, b, input logic [2:0] op, input bit rnd = 0);
      bit acc = 0;
      in_valid = 1; in_a = a; in_b = b; in_op = op;
      for (int i = 0; i < 200 && !acc; i++) begin
         if (rnd) out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("send_accept", 32'(acc), 1);
   endtask
   task automatic drain();
      out_ready = 1;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", q.size(), 0);
   endtask
   task automatic lat(input logic [15:0] a, b, input logic [2:0] op);
      out_ready = 1;
      in_valid = 1; in_a = a; in_b = b; in_op = op;
      @(negedge clk);
      chk("lat_accept", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      chk("lat_cycle1", 32'(out_valid), 0);
      @(negedge clk);
      chk("lat_cycle2", 32'(out_valid), 1);
      @(posedge clk); #1;
   endtask
   task automatic wait_out();
      for (int i = 0; i < 10 && !out_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("stall_valid", 32'(out_valid), 1);
   endtask
   initial begin
      rst_n = 0; in_valid = 0; out_ready = 0; ovf_clr = 0;
      in_a = 0; in_b = 0; in_op = 0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", out_result, 0);
      chk("rst_flags", out_flags, 0);
      chk("rst_sticky", 32'(ovf_sticky), 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 1);
      @(posedge clk); #1;
      lat(16'h7FFF, 16'h0001, ADD);
      chk("sticky_set", 32'(ovf_sticky), 1);
      out_ready = 1;
      send(16'h0005, 16'h0005, SUB);
      send(16'h0000, 16'h0001, SUB);
      send(16'h8001, 16'h0001, SHL);
      send(16'h0003, 16'h0002, SHR);
      send(16'h1234, 16'h0000, SHL);
      send(16'h8000, 16'h8000, ADD);
      send(16'h8000, 16'h0001, SUB);
      send(16'hF0F0, 16'h3C3C, AND_);
      send(16'hF0F0, 16'h3C3C, OR_);
      send(16'hF0F0, 16'hF0F0, XOR_);
      send(16'h00FF, 16'h0000, NOT_);
      send(16'hFFFF, 16'h000F, SHR);
      drain();
      out_ready = 0;
      send(16'h0001, 16'h0002, ADD);
      send(16'h0010, 16'h0003, SUB);
      in_valid = 1; in_a = 16'hAAAA; in_b = 16'h0004; in_op = SHL;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_hold_result", out_result, q[0].r);
         chk("bp_hold_flags", out_flags, q[0].f);
         @(posedge clk); #1;
      end
      out_ready = 1;
      send(16'hAAAA, 16'h0004, SHL);
      send(16'h5555, 16'h0003, SHR);
      drain();
      ovf_clr = 1;
      @(posedge clk); #1;
      ovf_clr = 0;
      chk("sticky_clr", 32'(ovf_sticky), 0);
      out_ready = 0;
      send(16'h7FFF, 16'h0001, ADD);
      wait_out();
      chk("sticky_before_xfer", 32'(ovf_sticky), 0);
      out_ready = 1; ovf_clr = 1;
      @(posedge clk); #1;
      chk("sticky_set_wins", 32'(ovf_sticky), 1);
      @(posedge clk); #1;
      chk("sticky_clr_alone", 32'(ovf_sticky), 0);
      ovf_clr = 0;
      send(16'h8000, 16'hFFFF, ADD);
      drain();
      out_ready = 0;
      send(16'h1234, 16'h1111, ADD);
      wait_out();
      chk("sticky_pre_rst", 32'(ovf_sticky), 1);
      #2 rst_n = 0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_result", out_result, 0);
      chk("async_rst_flags", out_flags, 0);
      chk("async_rst_sticky", 32'(ovf_sticky), 0);
      q.delete();
      npush = 0; npop = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("in_ready_after_rst2", 32'(in_ready), 1);
      @(posedge clk); #1;
      lat(16'h0003, 16'h0004, ADD);
      for (int i = 0; i < 40; i++)
         send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1);
      drain();
      chk("io_count", npop, npush);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
